// File: rtl/sample_source_pkg.sv
// Shared encodings for the strobed sample generator: mode codes, FSM states,
// LFSR seed/taps and square-wave half period.
package sample_source_pkg;

    typedef enum logic [1:0] {
        MODE_CONST  = 2'b00,
        MODE_RAMP   = 2'b01,
        MODE_SQUARE = 2'b10,
        MODE_LFSR   = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [9:0] LFSR_SEED   = 10'h001;
    localparam int         LFSR_TAP_HI = 9;
    localparam int         LFSR_TAP_LO = 6;

    localparam int SQ_HALF  = 8;
    localparam int SQ_CNT_W = $clog2(SQ_HALF);

    // x^10 + x^7 + 1, shifting left with feedback into bit 0
    function automatic logic [9:0] lfsr_step(input logic [9:0] s);
        return {s[8:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/sample_source_lfsr.sv
// 10-bit Fibonacci LFSR with advance enable; o_next is the value the register
// will take on the next advance.
module sample_source_lfsr
    import sample_source_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_adv,
    output logic [9:0] o_next
);

    logic [9:0] r_lfsr;

    assign o_next = lfsr_step(r_lfsr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_adv) begin
            r_lfsr <= o_next;
        end
    end

endmodule

// File: rtl/sample_source.sv
// Strobed sample generator: constant / ramp / square / LFSR samples at a
// programmable strobe period. Optional burst mode under SAMPLE_SOURCE_BURST_EN.
//
//   state | meaning
//   IDLE  | no strobes; data_o holds last sample, generator state kept
//   RUN   | divider counts; one strobe every period+1 cycles
module sample_source
    import sample_source_pkg::*;
#(
    parameter int DATA_LEN  = 10,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic [1:0]           mode_i,
    input  logic [DIV_WIDTH-1:0] period_i,
    input  logic [DATA_LEN-1:0]  amplitude_i,
`ifdef SAMPLE_SOURCE_BURST_EN
    input  logic [7:0]           burst_len_i,
    output logic                 done_o,
`endif
    output logic [DATA_LEN-1:0]  data_o,
    output logic                 strobe_o,
    output logic                 busy_o
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DIV_WIDTH-1:0]  w_div_nxt;
    logic [DIV_WIDTH-1:0]  r_period;
    logic [DIV_WIDTH-1:0]  w_period_nxt;
    logic                  w_tick;
    logic                  w_hold;
    logic                  w_burst_end;

    logic [DATA_LEN-1:0]   r_data;
    logic                  r_strobe;
    logic                  r_busy;

    logic [DATA_LEN-1:0]   r_ramp;
    logic [DATA_LEN-1:0]   w_ramp_nxt;
    logic                  r_phase;
    logic                  w_phase_nxt;
    logic [SQ_CNT_W-1:0]   r_sq_cnt;
    logic [SQ_CNT_W-1:0]   w_sq_cnt_nxt;
    logic [DATA_LEN-1:0]   w_sample;
    logic                  w_lfsr_adv;
    logic [9:0]            w_lfsr_next;
    logic [DATA_LEN-1:0]   w_lfsr_mask;

    sample_source_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_adv  (w_lfsr_adv),
        .o_next (w_lfsr_next)
    );

    assign w_lfsr_mask = DATA_LEN'(w_lfsr_next) & amplitude_i;

    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_period_nxt = r_period;
        w_tick       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable_i && !w_hold) begin
                    w_state_nxt  = RUN;
                    w_div_nxt    = '0;
                    w_period_nxt = period_i;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    w_state_nxt = IDLE;
                    w_div_nxt   = '0;
                end else if (r_div == r_period) begin
                    w_div_nxt    = '0;
                    w_period_nxt = period_i;
                    w_tick       = 1'b1;
                    if (w_burst_end) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Only the selected generator advances, so others resume where they left off
    always_comb begin
        w_sample     = amplitude_i;
        w_ramp_nxt   = r_ramp;
        w_phase_nxt  = r_phase;
        w_sq_cnt_nxt = r_sq_cnt;
        w_lfsr_adv   = 1'b0;
        unique case (mode_i)
            MODE_CONST: begin
                w_sample = amplitude_i;
            end
            MODE_RAMP: begin
                w_sample   = r_ramp;
                w_ramp_nxt = (r_ramp >= amplitude_i) ? '0 : r_ramp + 1'b1;
            end
            MODE_SQUARE: begin
                w_sample = r_phase ? amplitude_i : '0;
                if (r_sq_cnt == SQ_CNT_W'(SQ_HALF - 1)) begin
                    w_sq_cnt_nxt = '0;
                    w_phase_nxt  = ~r_phase;
                end else begin
                    w_sq_cnt_nxt = r_sq_cnt + 1'b1;
                end
            end
            MODE_LFSR: begin
                w_sample   = w_lfsr_mask;
                w_lfsr_adv = w_tick;
            end
            default: w_sample = amplitude_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_period <= '0;
            r_data   <= '0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_ramp   <= '0;
            r_phase  <= 1'b0;
            r_sq_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_period <= w_period_nxt;
            r_strobe <= w_tick;
            r_busy   <= (w_state_nxt == RUN);
            if (w_tick) begin
                r_data   <= w_sample;
                r_ramp   <= w_ramp_nxt;
                r_phase  <= w_phase_nxt;
                r_sq_cnt <= w_sq_cnt_nxt;
            end
        end
    end

`ifdef SAMPLE_SOURCE_BURST_EN
    logic [7:0] r_burst_len;
    logic [7:0] r_burst_cnt;
    logic       r_wait_low;
    logic       r_last;
    logic       r_done;

    assign w_hold      = r_wait_low;
    assign w_burst_end = (r_burst_len != 8'd0) && (r_burst_cnt == r_burst_len - 8'd1);

    // r_wait_low blocks restart until enable_i has been seen low after a burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_len <= '0;
            r_burst_cnt <= '0;
            r_wait_low  <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_last <= w_tick & w_burst_end;
            r_done <= r_last;
            if (r_state == IDLE) begin
                r_burst_cnt <= '0;
                if (enable_i && !r_wait_low) begin
                    r_burst_len <= burst_len_i;
                end
            end else if (w_tick) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end
            if (!enable_i) begin
                r_wait_low <= 1'b0;
            end else if (w_tick && w_burst_end) begin
                r_wait_low <= 1'b1;
            end
        end
    end

    assign done_o = r_done;
`else
    assign w_hold      = 1'b0;
    assign w_burst_end = 1'b0;
`endif

    assign data_o   = r_data;
    assign strobe_o = r_strobe;
    assign busy_o   = r_busy;

endmodule

// File: tb/tb_sample_source.sv
// Scoreboard bench for sample_source: stimulus pushes expected (cycle, data)
// pairs, a negedge monitor pops one per strobe and compares.
module tb_sample_source;

    logic       clk;
    logic       rst_n;
    logic       enable_i;
    logic [1:0] mode_i;
    logic [7:0] period_i;
    logic [9:0] amplitude_i;
    logic [9:0] data_o;
    logic       strobe_o;
    logic       busy_o;
`ifdef SAMPLE_SOURCE_BURST_EN
    logic [7:0] burst_len_i;
    logic       done_o;
`endif

    sample_source #(.DATA_LEN(10), .DIV_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable_i),
        .mode_i      (mode_i),
        .period_i    (period_i),
        .amplitude_i (amplitude_i),
`ifdef SAMPLE_SOURCE_BURST_EN
        .burst_len_i (burst_len_i),
        .done_o      (done_o),
`endif
        .data_o      (data_o),
        .strobe_o    (strobe_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        int         cyc;
        logic [9:0] data;
    } exp_t;

    exp_t       q[$];
    exp_t       m_e;
    logic [9:0] vq[$];
    int         cyc;
    int         total;
    int         bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && strobe_o) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got data %0h at cycle %0d, want no strobe", data_o, cyc);
            end else begin
                m_e = q.pop_front();
                chk("strobe_cycle", cyc, m_e.cyc);
                chk("strobe_data", {22'd0, data_o}, {22'd0, m_e.data});
            end
        end
    end

    task automatic push(input int c, input logic [9:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts a run, expects every value in vq at the nominal strobe cycles,
    // then drops enable right after the last strobe.
    task automatic stream(input logic [1:0] m, input logic [9:0] a, input logic [7:0] p);
        int k;
        int n;
        int last;
        mode_i      = m;
        amplitude_i = a;
        period_i    = p;
        enable_i    = 1'b1;
        k = cyc + 1;
        n = vq.size();
        for (int i = 0; i < n; i++) push(k + 1 + int'(p) + i * (int'(p) + 1), vq[i]);
        last = k + 1 + int'(p) + (n - 1) * (int'(p) + 1);
        vq.delete();
        tick_to(last);
        chk("busy_run", {31'd0, busy_o}, 32'd1);
        enable_i = 1'b0;
        tick_to(last + 1);
        chk("busy_off", {31'd0, busy_o}, 32'd0);
        chk("sb_empty", q.size(), 32'd0);
    endtask

    function automatic logic [9:0] mstep(input logic [9:0] s);
        return {s[8:0], s[9] ^ s[6]};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] s;
        int         k;
        cyc         = 0;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        enable_i    = 1'b1;
        mode_i      = 2'b00;
        period_i    = 8'd3;
        amplitude_i = 10'h155;
`ifdef SAMPLE_SOURCE_BURST_EN
        burst_len_i = 8'd0;
`endif
        #12;
        chk("rst_data", {22'd0, data_o}, 32'd0);
        chk("rst_strobe", {31'd0, strobe_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);

        // constant, P=3: first strobe at enable edge + 4, then every 4
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vq = '{10'h155, 10'h155, 10'h155};
        stream(2'b00, 10'h155, 8'd3);
        chk("const_hold", {22'd0, data_o}, 32'h155);

        // ramp amp=3 then amp=0 (ramp resumes at 2, then clamps to 0)
        vq = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd0, 10'd1};
        stream(2'b01, 10'd3, 8'd0);
        vq = '{10'd2, 10'd0, 10'd0, 10'd0};
        stream(2'b01, 10'd0, 8'd0);

        // LFSR full period: 1023 strobes return to seed, then repeat
        vq = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
               10'h040, 10'h081, 10'h102, 10'h204, 10'h009};
        s = 10'h009;
        for (int i = 11; i <= 1022; i++) begin
            s = mstep(s);
            vq.push_back(s);
        end
        vq.push_back(10'h001);
        vq.push_back(10'h002);
        vq.push_back(10'h004);
        vq.push_back(10'h008);
        stream(2'b11, 10'h3FF, 8'd0);

        // square, P=1: 8 zeros then high; interrupt after 10, resume phase
        vq = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
               10'h000, 10'h000, 10'h000, 10'h200, 10'h200};
        stream(2'b10, 10'h200, 8'd1);
        chk("sq_hold", {22'd0, data_o}, 32'h200);
        vq = '{10'h200, 10'h200, 10'h200, 10'h200, 10'h200,
               10'h200, 10'h000, 10'h000};
        stream(2'b10, 10'h200, 8'd1);

        // async reset while a strobe is on the outputs
        mode_i      = 2'b11;
        amplitude_i = 10'h3FF;
        period_i    = 8'd0;
        enable_i    = 1'b1;
        k = cyc + 1;
        push(k + 1, 10'h010);
        tick_to(k + 2);
        chk("pre_rst_strobe", {31'd0, strobe_o}, 32'd1);
        chk("pre_rst_data", {22'd0, data_o}, 32'h020);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_strobe", {31'd0, strobe_o}, 32'd0);
        chk("arst_data", {22'd0, data_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vq = '{10'h002, 10'h004, 10'h008};
        stream(2'b11, 10'h3FF, 8'd0);

`ifdef SAMPLE_SOURCE_BURST_EN
        // burst of 5 at P=2, then locked out until enable toggles
        mode_i      = 2'b00;
        amplitude_i = 10'h0AA;
        period_i    = 8'd2;
        burst_len_i = 8'd5;
        enable_i    = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 5; i++) push(k + 3 + 3 * i, 10'h0AA);
        tick_to(k + 15);
        chk("burst_done_early", {31'd0, done_o}, 32'd0);
        tick_to(k + 16);
        chk("burst_done", {31'd0, done_o}, 32'd1);
        chk("burst_busy", {31'd0, busy_o}, 32'd0);
        tick_to(k + 17);
        chk("burst_done_1cyc", {31'd0, done_o}, 32'd0);
        tick_to(k + 40);
        chk("burst_locked", {31'd0, busy_o}, 32'd0);
        chk("burst_sb_empty", q.size(), 32'd0);
        enable_i = 1'b0;
        tick_to(k + 41);
        burst_len_i = 8'd2;
        amplitude_i = 10'h0CC;
        enable_i    = 1'b1;
        k = cyc + 1;
        push(k + 3, 10'h0CC);
        push(k + 6, 10'h0CC);
        tick_to(k + 7);
        chk("burst2_done", {31'd0, done_o}, 32'd1);
        tick_to(k + 20);
        chk("burst2_sb_empty", q.size(), 32'd0);
        enable_i = 1'b0;
        tick_to(k + 21);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
